eflags_commit: RTL

//  Consumer end of the EX-stage ALU flag interface. Takes each ALU flag result (cf/pf/af/zf/sf/of/df, cc_inval) from EX and holds it in an in-order queue.

---
 rtl/eflags_commit_pkg.sv | 43 ++++
 rtl/eflags_apply.sv | 29 ++
 rtl/eflags_commit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/eflags_commit_pkg.sv
// Shared definitions for the EFLAGS commit slice: flag-vector layout,
// architectural bit positions and the EFLAGS reset value.
package eflags_commit_pkg;

    // Width of the ALU flag vector {df,of,sf,zf,af,pf,cf} and of its write mask
    localparam int unsigned NFLAGS = 7;

    // Index of each flag inside the ALU flag vector
    localparam int unsigned FI_CF = 0;
    localparam int unsigned FI_PF = 1;
    localparam int unsigned FI_AF = 2;
    localparam int unsigned FI_ZF = 3;
    localparam int unsigned FI_SF = 4;
    localparam int unsigned FI_OF = 5;
    localparam int unsigned FI_DF = 6;

    // Architectural bit positions inside EFLAGS
    localparam int unsigned CF_POS = 0;
    localparam int unsigned PF_POS = 2;
    localparam int unsigned AF_POS = 4;
    localparam int unsigned ZF_POS = 6;
    localparam int unsigned SF_POS = 7;
    localparam int unsigned DF_POS = 10;
    localparam int unsigned OF_POS = 11;

    // Bit 1 is the only constant-one bit
    localparam logic [31:0] EFLAGS_RESET = 32'h0000_0002;

    // Flag-vector index that owns a given EFLAGS bit, or NFLAGS if none does
    function automatic int unsigned flag_index(input int unsigned bitpos);
        case (bitpos)
            CF_POS:  return FI_CF;
            PF_POS:  return FI_PF;
            AF_POS:  return FI_AF;
            ZF_POS:  return FI_ZF;
            SF_POS:  return FI_SF;
            DF_POS:  return FI_DF;
            OF_POS:  return FI_OF;
            default: return NFLAGS;
        endcase
    endfunction

endpackage

// File: rtl/eflags_apply.sv
// Combinational merge of one {flags, mask} update into an EFLAGS value.
// Bits not owned by a flag pass through unchanged.
module eflags_apply
    import eflags_commit_pkg::*;
#(
    parameter int unsigned EFL_W = 32
) (
    input  logic [EFL_W-1:0]  eflags_in,
    input  logic [NFLAGS-1:0] flags,
    input  logic [NFLAGS-1:0] mask,
    output logic [EFL_W-1:0]  eflags_out
);

    for (genvar b = 0; b < EFL_W; b++) begin : g_bit
        localparam int unsigned FI = flag_index(b);
        if (FI < NFLAGS) begin : g_flag
            // Masked flag bits take the new value, others keep the old one
            always_comb begin
                eflags_out[b] = mask[FI] ? flags[FI] : eflags_in[b];
            end
        end else begin : g_pass
            // Non-flag bits are carried through untouched
            always_comb begin
                eflags_out[b] = eflags_in[b];
            end
        end
    end

endmodule

// File: rtl/eflags_commit.sv
// In-order flag-result queue between EX and retire, architectural EFLAGS
// register, and speculative CF/AF/OF/ZF forwarding back to the ALU.
// Optional macro: EFLAGS_PARITY_GEN_EN -- PF is generated from ex_res_lo
// instead of taken from ex_flags.
module eflags_commit
    import eflags_commit_pkg::*;
#(
    parameter int unsigned QDEPTH = 2,
    parameter int unsigned EFL_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [NFLAGS-1:0] ex_flags,
    input  logic [7:0]        ex_res_lo,
    input  logic [NFLAGS-1:0] ex_wmask,
    input  logic              ex_cc_inval,
    input  logic              flush,
    input  logic              rt_ready,
    output logic              rt_valid,
    output logic [EFL_W-1:0]  eflags,
    output logic              fwd_cf,
    output logic              fwd_af,
    output logic              fwd_of,
    output logic              fwd_zf
);

    localparam int unsigned       PTR_W    = $clog2(QDEPTH);
    localparam int unsigned       CNT_W    = $clog2(QDEPTH + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(QDEPTH);
    localparam logic [EFL_W-1:0]  RST_VAL  = EFL_W'(EFLAGS_RESET);

    logic [NFLAGS-1:0] q_flags [QDEPTH];
    logic [NFLAGS-1:0] q_mask  [QDEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  head_nxt;
    logic [CNT_W-1:0]  count;

    logic              push;
    logic              pop;
    logic [NFLAGS-1:0] enq_flags;
    logic [NFLAGS-1:0] enq_mask;
    logic [EFL_W-1:0]  commit_val;

    logic [EFL_W-1:0]  fwd_chain [QDEPTH+1];
    logic              unused_fwd_bits;

    assign ex_ready = (count != CNT_FULL);
    assign rt_valid = (count != '0);
    assign push     = ex_valid & ex_ready;
    assign pop      = rt_valid & rt_ready;
    assign head_nxt = pop ? head + 1'b1 : head;
    assign enq_mask = ex_wmask & ~{NFLAGS{ex_cc_inval}};

`ifdef EFLAGS_PARITY_GEN_EN
    logic unused_pf_in;
    // PF is rebuilt as even parity of the result low byte
    always_comb begin
        enq_flags        = ex_flags;
        enq_flags[FI_PF] = ~^ex_res_lo;
        unused_pf_in     = ex_flags[FI_PF];
    end
`else
    logic unused_res_lo;
    // PF comes straight from the ALU; the result byte is not needed
    always_comb begin
        enq_flags     = ex_flags;
        unused_res_lo = ^ex_res_lo;
    end
`endif

    // Queue pointers, occupancy, entry storage and architectural EFLAGS
    always_ff @(posedge clk) begin
        if (rst) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            eflags <= RST_VAL;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                q_flags[i] <= '0;
                q_mask[i]  <= '0;
            end
        end else begin
            if (pop) begin
                eflags <= commit_val;
            end
            head <= head_nxt;
            // Flush empties the queue behind a possible same-cycle commit by
            // collapsing tail onto the post-commit head; enqueue is dropped.
            if (flush) begin
                tail  <= head_nxt;
                count <= '0;
            end else begin
                if (push) begin
                    q_flags[tail] <= enq_flags;
                    q_mask[tail]  <= enq_mask;
                    tail          <= tail + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (!push && pop) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    eflags_apply #(.EFL_W(EFL_W)) u_commit (
        .eflags_in  (eflags),
        .flags      (q_flags[head]),
        .mask       (q_mask[head]),
        .eflags_out (commit_val)
    );

    assign fwd_chain[0] = eflags;

    // Forwarding chain: stage k applies the k-th oldest entry; stages beyond
    // the current occupancy get a zero mask so stale slots have no effect.
    for (genvar k = 0; k < QDEPTH; k++) begin : g_fwd
        localparam logic [PTR_W-1:0] OFF = PTR_W'(k);
        localparam logic [CNT_W-1:0] ORD = CNT_W'(k);
        logic [PTR_W-1:0]  idx;
        logic [NFLAGS-1:0] live_mask;

        assign idx       = head + OFF;
        assign live_mask = (ORD < count) ? q_mask[idx] : '0;

        eflags_apply #(.EFL_W(EFL_W)) u_apply (
            .eflags_in  (fwd_chain[k]),
            .flags      (q_flags[idx]),
            .mask       (live_mask),
            .eflags_out (fwd_chain[k+1])
        );
    end

    assign fwd_cf          = fwd_chain[QDEPTH][CF_POS];
    assign fwd_af          = fwd_chain[QDEPTH][AF_POS];
    assign fwd_of          = fwd_chain[QDEPTH][OF_POS];
    assign fwd_zf          = fwd_chain[QDEPTH][ZF_POS];
    assign unused_fwd_bits = ^fwd_chain[QDEPTH];

endmodule
